// File: rtl/qspi_ddr_txser.sv
// rtl/qspi_ddr_txser.sv - QSPI transmit serializer producing per-clock DDR patterns for SCK and DQ[3:0]
// One system clock equals one SCK period; outputs are registered alongside the state they belong to.
module qspi_ddr_txser #(
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1,
    parameter int CS_HIGH  = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_stb,
    input  logic [7:0] i_byte,
    input  logic       i_quad,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_cs_n,
    output logic [1:0] o_sck,
    output logic [7:0] o_dq,
    output logic [3:0] o_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_STALL,
        ST_HOLD,
        ST_DESEL
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d;
    logic       quad_q, quad_d;
    logic       last_q, last_d;

    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       cs_n_q, cs_n_d;
    logic [1:0] sck_q, sck_d;
    logic [7:0] dq_q, dq_d;
    logic [3:0] oe_q, oe_d;

    logic       accept;
    logic       byte_end_q;
    logic       byte_end_d;
    logic [3:0] nib_d;
    logic       bit_val_d;

    assign accept     = i_stb & ready_q;
    assign byte_end_q = quad_q ? (bit_q == 3'd1) : (bit_q == 3'd7);
    assign byte_end_d = quad_d ? (bit_d == 3'd1) : (bit_d == 3'd7);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            byte_q  <= 8'd0;
            quad_q  <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 2'b00;
            dq_q    <= 8'hFF;
            oe_q    <= 4'b1101;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            quad_q  <= quad_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        quad_d  = quad_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    byte_d  = i_byte;
                    quad_d  = i_quad;
                    last_d  = i_last;
                    bit_d   = 3'd0;
                    cnt_d   = 4'(CS_SETUP - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) state_d = ST_SHIFT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_SHIFT: begin
                if (!byte_end_q) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    bit_d = 3'd0;
                    if (last_q) begin
                        cnt_d   = 4'(CS_HOLD - 1);
                        state_d = ST_HOLD;
                    end else if (accept) begin
                        byte_d = i_byte;
                        quad_d = i_quad;
                        last_d = i_last;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (accept) begin
                    byte_d  = i_byte;
                    quad_d  = i_quad;
                    last_d  = i_last;
                    bit_d   = 3'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'(CS_HIGH - 1);
                    state_d = ST_DESEL;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DESEL: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they land in the same cycle as that state.
    always_comb begin
        cs_n_d    = 1'b1;
        sck_d     = 2'b00;
        dq_d      = 8'hFF;
        oe_d      = 4'b1101;
        ready_d   = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        nib_d     = (bit_d == 3'd0) ? byte_d[7:4] : byte_d[3:0];
        bit_val_d = byte_d[3'd7 - bit_d];
        case (state_d)
            ST_IDLE:  ready_d = 1'b1;
            ST_SETUP: cs_n_d  = 1'b0;
            ST_SHIFT: begin
                cs_n_d  = 1'b0;
                sck_d   = 2'b01;
                ready_d = byte_end_d & ~last_d;
                if (quad_d) begin
                    dq_d = {{2{nib_d[3]}}, {2{nib_d[2]}}, {2{nib_d[1]}}, {2{nib_d[0]}}};
                    oe_d = 4'b1111;
                end else begin
                    dq_d = {6'h3F, {2{bit_val_d}}};
                    oe_d = 4'b1101;
                end
            end
            ST_STALL: begin
                cs_n_d  = 1'b0;
                dq_d    = dq_q;
                oe_d    = oe_q;
                ready_d = 1'b1;
            end
            ST_HOLD: begin
                cs_n_d = 1'b0;
                dq_d   = dq_q;
                oe_d   = oe_q;
            end
            default: ;
        endcase
    end

    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_cs_n  = cs_n_q;
    assign o_sck   = sck_q;
    assign o_dq    = dq_q;
    assign o_oe    = oe_q;

endmodule
